pkt_desc_sched: RTL and testbench
=================================

PKT_DESC_SCHED -- requirements
Module: pkt_desc_sched

Interface
REQ-001 Parameter DEPTH, default 8, SHALL set descriptor queue entries (power of 2, 2..64).
REQ-002 Parameter START_TMO, default 16, SHALL set the cycles allowed for the reader to leave ready after a start pulse.
REQ-003 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  SHALL be an asynchronous, active-high reset.
REQ-005 enable  in  1  SHALL allow new packet issue when high.
REQ-006 desc_valid  in  1  SHALL qualify a descriptor offered by the producer.
REQ-007 desc_ready  out  1  SHALL indicate the queue accepts a descriptor this cycle.
REQ-008 desc_control, desc_begin, desc_end  in  32 each  SHALL carry the control word, start byte address and end byte address (exclusive).
REQ-009 rd_ctrl  out  1  SHALL be the one-cycle start pulse to the packet reader.
REQ-010 control, pkt_begin, pkt_end  out  32 each  SHALL present the active descriptor to the reader.
REQ-011 rd_ctrl_rdy  in  1  SHALL be high while the reader is idle.
REQ-012 busy  out  1; q_level  out  $clog2(DEPTH)+1; pkt_count  out  16; err_count  out  8  SHALL be status outputs.

Function
REQ-013 A descriptor SHALL be accepted on a cycle where desc_valid and desc_ready are both high; desc_ready SHALL equal (q_level < DEPTH).
REQ-014 An accepted descriptor with desc_end <= desc_begin, or with either address not 4-byte aligned, SHALL be discarded, not queued, and SHALL increment err_count.
REQ-015 Valid descriptors SHALL be issued in acceptance order.
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT_START, WAIT_DONE.
REQ-017 IDLE -> ISSUE when enable, queue non-empty and rd_ctrl_rdy; the head entry SHALL be popped and latched onto control/pkt_begin/pkt_end in that transition.
REQ-018 ISSUE SHALL assert rd_ctrl for exactly one cycle, then go to WAIT_START.
REQ-019 WAIT_START -> WAIT_DONE when rd_ctrl_rdy is low; if rd_ctrl_rdy stays high for START_TMO cycles, it SHALL go to IDLE, increment err_count and not increment pkt_count.
REQ-020 WAIT_DONE -> IDLE when rd_ctrl_rdy returns high, incrementing pkt_count.
REQ-021 control/pkt_begin/pkt_end SHALL remain stable from ISSUE until the next pop.
REQ-022 busy SHALL be high in every state except IDLE.
REQ-023 Issue-to-issue minimum spacing SHALL be 4 cycles (IDLE, ISSUE, WAIT_START, WAIT_DONE).
REQ-024 Simultaneous push and pop SHALL leave q_level unchanged; a push to a queue full at the start of the cycle SHALL not occur, since desc_ready is low.
REQ-025 Deasserting enable SHALL not abort an in-flight packet; it SHALL only block the next IDLE -> ISSUE transition.
REQ-026 pkt_count SHALL wrap modulo 2^16; err_count SHALL saturate at 255.
REQ-027 Queue pointers SHALL wrap modulo DEPTH.

Reset
REQ-028 On reset, the FSM SHALL enter IDLE, the queue SHALL empty, and rd_ctrl, busy, q_level, pkt_count, err_count, control, pkt_begin and pkt_end SHALL be 0; desc_ready SHALL be 1 after reset deasserts.
REQ-029 Reset asserted mid-packet SHALL take effect immediately: rd_ctrl low, and queued descriptors lost.

Structure
REQ-030 Package pkt_sched_pkg SHALL hold the desc_t struct (control, begin, end), the state enum and the default constants.
REQ-031 The queue SHALL be a sub-module desc_fifo (synchronous FIFO of desc_t, DEPTH entries, level output).

Verification
REQ-032 Push {0, 0x0, 0x20} with a reader model that drops rdy 2 cycles after rd_ctrl and restores it 8 cycles later -> one rd_ctrl pulse, pkt_begin=0x0, pkt_end=0x20, pkt_count=1.
REQ-033 Push 9 descriptors back-to-back with DEPTH=8 and the reader held busy -> desc_ready low after 8 accepts, q_level=8, then all 9 issued in order.
REQ-034 Push {0, 0x40, 0x40} and {0, 0x3, 0x20} -> neither issued, err_count=2, q_level=0.
REQ-035 Reader ignores rd_ctrl (rdy stays high) -> return to IDLE after 16 cycles, err_count=1, pkt_count=0, next descriptor issued.
REQ-036 Assert reset during WAIT_DONE with 3 descriptors queued -> all outputs 0, q_level=0, no further rd_ctrl.
REQ-037 enable=0 with 2 descriptors queued -> no rd_ctrl; enable=1 -> issue within 2 cycles.

Source files
------------

// File: rtl/pkt_sched_pkg.sv
// Shared types and defaults for the packet descriptor scheduler.
// Holds the queued descriptor record, the issue FSM states and the validity rule.
package pkt_sched_pkg;

  localparam int DEFAULT_DEPTH     = 8;
  localparam int DEFAULT_START_TMO = 16;

  typedef struct packed {
    logic [31:0] ctrl;
    logic [31:0] addr_begin;
    logic [31:0] addr_end;
  } desc_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    WAIT_DONE
  } state_e;

  // A descriptor must describe a non-empty, word-aligned byte range (end is exclusive).
  function automatic logic desc_bad(input desc_t d);
    return (d.addr_end <= d.addr_begin) ||
           (d.addr_begin[1:0] != 2'b00) ||
           (d.addr_end[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/desc_fifo.sv
// Synchronous FIFO of descriptors with a fill-level output.
// Head entry is presented combinationally so it can be latched on the pop edge.
module desc_fifo
  import pkt_sched_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  logic        pop_i,
  input  desc_t       wdata_i,
  output desc_t       rdata_o,
  output logic [AW:0] level_o,
  output logic        full_o,
  output logic        empty_o
);

  desc_t         mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   level_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/pkt_desc_sched.sv
// Packet descriptor scheduler: queues valid descriptors and hands them one at a
// time to a packet reader with a start-pulse / ready handshake and a start timeout.
module pkt_desc_sched
  import pkt_sched_pkg::*;
#(
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int START_TMO = DEFAULT_START_TMO,
  localparam int LW       = $clog2(DEPTH) + 1,
  localparam int TW       = $clog2(START_TMO) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          enable_i,
  input  logic          desc_valid_i,
  output logic          desc_ready_o,
  input  logic [31:0]   desc_control_i,
  input  logic [31:0]   desc_begin_i,
  input  logic [31:0]   desc_end_i,
  output logic          rd_ctrl_o,
  output logic [31:0]   control_o,
  output logic [31:0]   pkt_begin_o,
  output logic [31:0]   pkt_end_o,
  input  logic          rd_ctrl_rdy_i,
  output logic          busy_o,
  output logic [LW-1:0] q_level_o,
  output logic [15:0]   pkt_count_o,
  output logic [7:0]    err_count_o
);

  desc_t         in_desc;
  desc_t         head;
  desc_t         active_q;
  state_e        state_q;
  logic [TW-1:0] tmo_cnt_q;
  logic [15:0]   pkt_count_q;
  logic [7:0]    err_count_q;
  logic [7:0]    err_count_d;
  logic [8:0]    err_sum;
  logic          rd_ctrl_q;
  logic          busy_q;
  logic          accept, bad, push, pop, full, empty, tmo_hit;

  assign in_desc      = '{ctrl: desc_control_i, addr_begin: desc_begin_i, addr_end: desc_end_i};
  assign desc_ready_o = (q_level_o < LW'(DEPTH));
  assign accept       = desc_valid_i && desc_ready_o;
  assign bad          = desc_bad(in_desc);
  assign push         = accept && !bad;
  assign pop          = (state_q == IDLE) && enable_i && !empty && rd_ctrl_rdy_i;
  assign tmo_hit      = (state_q == WAIT_START) && rd_ctrl_rdy_i &&
                        (tmo_cnt_q == TW'(START_TMO - 1));

  desc_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (in_desc),
    .rdata_o (head),
    .level_o (q_level_o),
    .full_o  (full),
    .empty_o (empty)
  );

  // A rejected push and a start timeout can land on the same edge, so both are summed.
  always_comb begin
    err_sum     = {1'b0, err_count_q} + 9'(accept && bad) + 9'(tmo_hit);
    err_count_d = (err_sum > 9'd255) ? 8'hFF : err_sum[7:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      active_q    <= '0;
      tmo_cnt_q   <= '0;
      pkt_count_q <= '0;
      err_count_q <= '0;
      rd_ctrl_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      err_count_q <= err_count_d;
      rd_ctrl_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop) begin
            active_q  <= head;
            rd_ctrl_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          tmo_cnt_q <= '0;
          state_q   <= WAIT_START;
        end
        WAIT_START: begin
          if (!rd_ctrl_rdy_i) begin
            state_q <= WAIT_DONE;
          end else if (tmo_hit) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (rd_ctrl_rdy_i) begin
            pkt_count_q <= pkt_count_q + 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_ctrl_o   = rd_ctrl_q;
  assign busy_o      = busy_q;
  assign control_o   = active_q.ctrl;
  assign pkt_begin_o = active_q.addr_begin;
  assign pkt_end_o   = active_q.addr_end;
  assign pkt_count_o = pkt_count_q;
  assign err_count_o = err_count_q;

endmodule

// File: tb/tb_pkt_desc_sched.sv
// Directed self-checking bench for pkt_desc_sched with a behavioural packet reader.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_pkt_desc_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        descValid = 1'b0;
  logic        descReady;
  logic [31:0] descControl = '0;
  logic [31:0] descBegin = '0;
  logic [31:0] descEnd = '0;
  logic        rdCtrl;
  logic [31:0] control, pktBegin, pktEnd;
  logic        rdCtrlRdy = 1'b1;
  logic        busy;
  logic [3:0]  qLevel;
  logic [15:0] pktCount;
  logic [7:0]  errCount;

  int          checks = 0;
  int          errors = 0;
  int          readerMode = 0;
  int          dropCnt = 0;
  int          holdCnt = 0;
  logic [31:0] issued[$];

  pkt_desc_sched #(.DEPTH(8), .START_TMO(16)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .enable_i       (enable),
    .desc_valid_i   (descValid),
    .desc_ready_o   (descReady),
    .desc_control_i (descControl),
    .desc_begin_i   (descBegin),
    .desc_end_i     (descEnd),
    .rd_ctrl_o      (rdCtrl),
    .control_o      (control),
    .pkt_begin_o    (pktBegin),
    .pkt_end_o      (pktEnd),
    .rd_ctrl_rdy_i  (rdCtrlRdy),
    .busy_o         (busy),
    .q_level_o      (qLevel),
    .pkt_count_o    (pktCount),
    .err_count_o    (errCount)
  );

  always #5 clk = ~clk;

  // Reader model: mode 0 drops ready 2 cycles after a start pulse and restores it
  // 8 cycles later, mode 1 ignores start pulses, mode 2 stays busy. Also logs issues.
  always @(negedge clk) begin
    if (rst) begin
      dropCnt = 0;
      holdCnt = 0;
      rdCtrlRdy = 1'b1;
    end else if (readerMode == 2) begin
      rdCtrlRdy = 1'b0;
    end else if (readerMode == 1) begin
      rdCtrlRdy = 1'b1;
    end else if (holdCnt > 0) begin
      holdCnt--;
      if (holdCnt == 0) rdCtrlRdy = 1'b1;
    end else if (dropCnt > 0) begin
      dropCnt--;
      if (dropCnt == 0) begin
        rdCtrlRdy = 1'b0;
        holdCnt = 8;
      end
    end else begin
      rdCtrlRdy = 1'b1;
      if (rdCtrl) dropCnt = 2;
    end
    if (!rst && rdCtrl) issued.push_back(pktBegin);
  end

  // Every comparison in the bench funnels through here.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Offers one descriptor starting on a falling edge and returns on the falling edge after acceptance.
  task automatic applyStimulus(input logic [31:0] c, input logic [31:0] b, input logic [31:0] e);
    int n = 0;
    descControl = c;
    descBegin = b;
    descEnd = e;
    descValid = 1'b1;
    while (!descReady && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) checkOutput("push_timeout", 32'(n), 0);
    @(negedge clk);
    descValid = 1'b0;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issued.delete();
  endtask

  task automatic waitDrain();
    int n = 0;
    @(negedge clk);
    while ((busy || qLevel != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) checkOutput("drain_timeout", 32'(n), 0);
  endtask

  function automatic logic [31:0] issuedAt(input int idx);
    return (idx < issued.size()) ? issued[idx] : 32'hDEAD_BEEF;
  endfunction

  initial begin
    int n;
    int cnt;

    // Reset values
    applyReset();
    checkOutput("rst_rd_ctrl", 32'(rdCtrl), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_q_level", 32'(qLevel), 0);
    checkOutput("rst_pkt_count", 32'(pktCount), 0);
    checkOutput("rst_err_count", 32'(errCount), 0);
    checkOutput("rst_control", control, 0);
    checkOutput("rst_pkt_begin", pktBegin, 0);
    checkOutput("rst_pkt_end", pktEnd, 0);
    checkOutput("rst_desc_ready", 32'(descReady), 1);

    // Single packet through the normal handshake
    $display("[TB] single packet");
    enable = 1'b1;
    readerMode = 0;
    applyStimulus(32'h0, 32'h0, 32'h20);
    waitDrain();
    checkOutput("single_pulses", 32'(issued.size()), 1);
    checkOutput("single_issued", issuedAt(0), 32'h0);
    checkOutput("single_pkt_begin", pktBegin, 32'h0);
    checkOutput("single_pkt_end", pktEnd, 32'h20);
    checkOutput("single_pkt_count", 32'(pktCount), 1);

    // Fill the queue while the reader is busy, then drain in order
    $display("[TB] queue full");
    applyReset();
    readerMode = 2;
    @(negedge clk);
    for (int i = 0; i < 8; i++)
      applyStimulus(32'(i), 32'((i + 1) * 256), 32'((i + 1) * 256 + 16));
    checkOutput("full_q_level", 32'(qLevel), 8);
    checkOutput("full_desc_ready", 32'(descReady), 0);
    checkOutput("full_no_issue", 32'(issued.size()), 0);
    readerMode = 0;
    applyStimulus(32'd8, 32'h900, 32'h910);
    waitDrain();
    checkOutput("full_issue_count", 32'(issued.size()), 9);
    for (int i = 0; i < 9; i++)
      checkOutput($sformatf("full_order_%0d", i), issuedAt(i), 32'((i + 1) * 256));
    checkOutput("full_pkt_count", 32'(pktCount), 9);

    // Malformed descriptors are dropped and counted, saturating at 255
    $display("[TB] bad descriptors");
    applyReset();
    applyStimulus(32'h0, 32'h40, 32'h40);
    applyStimulus(32'h0, 32'h3, 32'h20);
    repeat (3) @(negedge clk);
    checkOutput("bad_err_count", 32'(errCount), 2);
    checkOutput("bad_q_level", 32'(qLevel), 0);
    checkOutput("bad_no_issue", 32'(issued.size()), 0);
    for (int i = 0; i < 260; i++) applyStimulus(32'h0, 32'h10, 32'h8);
    checkOutput("bad_err_saturate", 32'(errCount), 255);

    // Reader ignores the start pulse
    $display("[TB] start timeout");
    applyReset();
    readerMode = 1;
    @(negedge clk);
    applyStimulus(32'h0, 32'h200, 32'h240);
    applyStimulus(32'h0, 32'h300, 32'h340);
    n = 0;
    while (!rdCtrl && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("tmo_saw_pulse", 32'(rdCtrl), 1);
    cnt = 0;
    @(negedge clk);
    while (busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    checkOutput("tmo_cycles", 32'(cnt), 16);
    checkOutput("tmo_err_count", 32'(errCount), 1);
    checkOutput("tmo_pkt_count", 32'(pktCount), 0);
    readerMode = 0;
    waitDrain();
    checkOutput("tmo_next_issued", issuedAt(1), 32'h300);
    checkOutput("tmo_final_pkt_count", 32'(pktCount), 1);
    checkOutput("tmo_final_err_count", 32'(errCount), 1);

    // Reset in the middle of a packet with three entries queued
    $display("[TB] mid-packet reset");
    applyReset();
    readerMode = 0;
    applyStimulus(32'h1, 32'h400, 32'h440);
    applyStimulus(32'h2, 32'h500, 32'h540);
    applyStimulus(32'h3, 32'h600, 32'h640);
    applyStimulus(32'h4, 32'h700, 32'h740);
    n = 0;
    while (!(busy && !rdCtrlRdy) && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checkOutput("mid_pre_q_level", 32'(qLevel), 3);
    checkOutput("mid_pre_pkt_begin", pktBegin, 32'h400);
    #1 rst = 1'b1;
    #1;
    checkOutput("mid_rd_ctrl", 32'(rdCtrl), 0);
    checkOutput("mid_busy", 32'(busy), 0);
    checkOutput("mid_q_level", 32'(qLevel), 0);
    checkOutput("mid_control", control, 0);
    checkOutput("mid_pkt_begin", pktBegin, 0);
    checkOutput("mid_pkt_end", pktEnd, 0);
    @(negedge clk);
    rst = 1'b0;
    issued.delete();
    repeat (30) @(negedge clk);
    checkOutput("mid_no_issue", 32'(issued.size()), 0);
    checkOutput("mid_post_busy", 32'(busy), 0);

    // enable gates new issues only
    $display("[TB] enable gating");
    applyReset();
    enable = 1'b0;
    applyStimulus(32'h0, 32'h800, 32'h840);
    applyStimulus(32'h0, 32'h900, 32'h940);
    repeat (10) @(negedge clk);
    checkOutput("en_no_issue", 32'(issued.size()), 0);
    checkOutput("en_q_level", 32'(qLevel), 2);
    enable = 1'b1;
    n = 0;
    while (!rdCtrl && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("en_latency_ok", 32'(n >= 1 && n <= 2), 1);
    waitDrain();
    checkOutput("en_first", issuedAt(0), 32'h800);
    checkOutput("en_second", issuedAt(1), 32'h900);
    checkOutput("en_pkt_count", 32'(pktCount), 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
